// File: rtl/iiitb_rv32i_pkg.sv
// Shared RV32I-subset constants for the MEM/WB stage: opcodes, funct3 codes,
// FSM state encoding and a small instruction classifier.
package iiitb_rv32i_pkg;

  localparam logic [6:0] AR_TYPE = 7'd0;
  localparam logic [6:0] M_TYPE  = 7'd1;
  localparam logic [6:0] BR_TYPE = 7'd2;
  localparam logic [6:0] SH_TYPE = 7'd3;

  localparam logic [2:0] LW = 3'd0;
  localparam logic [2:0] SW = 3'd1;

  typedef enum logic {
    IDLE      = 1'b0,
    LOAD_WAIT = 1'b1
  } state_t;

  // What the stage has to do with an accepted bundle.
  typedef enum logic [1:0] {
    OP_WB   = 2'd0,  // ALU result goes straight to the register file
    OP_LW   = 2'd1,
    OP_SW   = 2'd2,
    OP_NONE = 2'd3   // branches and undefined encodings: retire only
  } op_class_t;

  function automatic op_class_t classify(input logic [14:0] ir);
    op_class_t cls;
    cls = OP_NONE;
    case (ir[6:0])
      AR_TYPE, SH_TYPE: cls = OP_WB;
      M_TYPE: begin
        if (ir[14:12] == LW)      cls = OP_LW;
        else if (ir[14:12] == SW) cls = OP_SW;
      end
      default: cls = OP_NONE;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/iiitb_dmem.sv
// DM_DEPTH x 32 data memory: one synchronous write port, one synchronous
// read port whose output register only changes when a read is requested.
module iiitb_dmem #(
  parameter int DM_DEPTH = 32,
  localparam int AW = $clog2(DM_DEPTH)
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [31:0]   i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [31:0]   o_rdata
);

  logic [31:0] r_mem [DM_DEPTH];

  // NOTE: the array has no reset on purpose; contents survive RN and a reset
  // term here would stop it mapping onto RAM.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) o_rdata <= r_mem[i_raddr];
  end

endmodule

// File: rtl/iiitb_mem_wb.sv
// MEM/WB stage: stores/loads against iiitb_dmem and drives the register-file
// write port. Define IIITB_MEM_WB_FWD_EN to add the fwd_* forwarding outputs.
module iiitb_mem_wb
  import iiitb_rv32i_pkg::*;
#(
  parameter int DM_DEPTH = 32
) (
  input  logic        clk,
  input  logic        RN,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic [31:0] ex_ir,
  input  logic [31:0] ex_aluout,
  input  logic [31:0] ex_b,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic [31:0] WB_OUT,
  output logic [31:0] retire_cnt,
  output logic        dm_err
`ifdef IIITB_MEM_WB_FWD_EN
  ,
  output logic        fwd_valid,
  output logic [4:0]  fwd_rd,
  output logic [31:0] fwd_data
`endif
);

  localparam int AW = $clog2(DM_DEPTH);

  state_t      r_state;
  logic        r_ex_ready;
  logic [4:0]  r_ld_rd;
  logic        r_ld_oor;

  logic        w_accept;
  op_class_t   w_cls;
  logic [4:0]  w_rd;
  logic        w_oor;
  logic [AW-1:0] w_addr;
  logic        w_dm_we;
  logic        w_dm_re;
  logic [31:0] w_dm_rdata;
  logic [31:0] w_ld_data;
  logic        w_unused_ir;

  assign w_accept    = ex_valid && r_ex_ready;
  assign w_cls       = classify(ex_ir[14:0]);
  assign w_rd        = ex_ir[11:7];
  assign w_oor       = |ex_aluout[31:AW];
  assign w_addr      = ex_aluout[AW-1:0];
  assign w_dm_we     = w_accept && (w_cls == OP_SW) && !w_oor;
  assign w_dm_re     = w_accept && (w_cls == OP_LW);
  // An out-of-range load still reads (aliased) memory; the result is masked.
  assign w_ld_data   = r_ld_oor ? 32'd0 : w_dm_rdata;
  assign w_unused_ir = ^ex_ir[31:15];
  assign ex_ready    = r_ex_ready;

  iiitb_dmem #(.DM_DEPTH(DM_DEPTH)) u_dmem (
    .clk     (clk),
    .i_we    (w_dm_we),
    .i_waddr (w_addr),
    .i_wdata (ex_b),
    .i_re    (w_dm_re),
    .i_raddr (w_addr),
    .o_rdata (w_dm_rdata)
  );

  // NOTE: every register below is assigned with <= so all of them see the
  // pre-edge values, whatever order the statements appear in.
  always_ff @(posedge clk) begin
    if (RN) begin
      r_state    <= IDLE;
      r_ex_ready <= 1'b1;
      r_ld_rd    <= 5'd0;
      r_ld_oor   <= 1'b0;
      rf_we      <= 1'b0;
      rf_waddr   <= 5'd0;
      rf_wdata   <= 32'd0;
      WB_OUT     <= 32'd0;
      retire_cnt <= 32'd0;
      dm_err     <= 1'b0;
    end else begin
      rf_we <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            case (w_cls)
              OP_WB: begin
                // x0 writes are suppressed but the instruction still retires.
                rf_we      <= (w_rd != 5'd0);
                rf_waddr   <= w_rd;
                rf_wdata   <= ex_aluout;
                if (w_rd != 5'd0) WB_OUT <= ex_aluout;
                retire_cnt <= retire_cnt + 32'd1;
              end
              OP_LW: begin
                r_state    <= LOAD_WAIT;
                r_ex_ready <= 1'b0;
                r_ld_rd    <= w_rd;
                r_ld_oor   <= w_oor;
                if (w_oor) dm_err <= 1'b1;
              end
              OP_SW: begin
                if (w_oor) dm_err <= 1'b1;
                retire_cnt <= retire_cnt + 32'd1;
              end
              default: retire_cnt <= retire_cnt + 32'd1;
            endcase
          end
        end
        LOAD_WAIT: begin
          r_state    <= IDLE;
          r_ex_ready <= 1'b1;
          rf_we      <= (r_ld_rd != 5'd0);
          rf_waddr   <= r_ld_rd;
          rf_wdata   <= w_ld_data;
          if (r_ld_rd != 5'd0) WB_OUT <= w_ld_data;
          retire_cnt <= retire_cnt + 32'd1;
        end
        default: begin
          r_state    <= IDLE;
          r_ex_ready <= 1'b1;
        end
      endcase
    end
  end

`ifdef IIITB_MEM_WB_FWD_EN
  assign fwd_valid = rf_we;
  assign fwd_rd    = rf_waddr;
  assign fwd_data  = rf_wdata;
`endif

endmodule

// File: tb/tb_iiitb_mem_wb.sv
// Table-driven bench for iiitb_mem_wb: each row is one cycle of stimulus and
// the outputs expected just after that rising edge.
module tb_iiitb_mem_wb;

  logic        clk = 1'b0;
  logic        RN;
  logic        ex_valid;
  logic        ex_ready;
  logic [31:0] ex_ir;
  logic [31:0] ex_aluout;
  logic [31:0] ex_b;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [31:0] WB_OUT;
  logic [31:0] retire_cnt;
  logic        dm_err;
`ifdef IIITB_MEM_WB_FWD_EN
  logic        fwd_valid;
  logic [4:0]  fwd_rd;
  logic [31:0] fwd_data;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  iiitb_mem_wb #(.DM_DEPTH(32)) dut (
    .clk        (clk),
    .RN         (RN),
    .ex_valid   (ex_valid),
    .ex_ready   (ex_ready),
    .ex_ir      (ex_ir),
    .ex_aluout  (ex_aluout),
    .ex_b       (ex_b),
    .rf_we      (rf_we),
    .rf_waddr   (rf_waddr),
    .rf_wdata   (rf_wdata),
    .WB_OUT     (WB_OUT),
    .retire_cnt (retire_cnt),
    .dm_err     (dm_err)
`ifdef IIITB_MEM_WB_FWD_EN
    ,
    .fwd_valid  (fwd_valid),
    .fwd_rd     (fwd_rd),
    .fwd_data   (fwd_data)
`endif
  );

  typedef struct {
    logic        rn;
    logic        vld;
    logic [31:0] ir;
    logic [31:0] alu;
    logic [31:0] b;
    logic        rdy;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [31:0] wb;
    logic [31:0] cnt;
    logic        err;
    logic        dchk;  // compare rf_waddr/rf_wdata even when rf_we is low
  } vec_t;

  vec_t vt[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [31:0] mk_ir(input logic [6:0] op, input logic [4:0] rd,
                                        input logic [2:0] f3);
    return {17'd0, f3, rd, op};
  endfunction

  function automatic vec_t v(input logic rn, input logic vld, input logic [31:0] ir,
                             input logic [31:0] alu, input logic [31:0] b,
                             input logic rdy, input logic we, input logic [4:0] wa,
                             input logic [31:0] wd, input logic [31:0] wb,
                             input logic [31:0] cnt, input logic err, input logic dchk);
    vec_t r;
    r.rn = rn; r.vld = vld; r.ir = ir; r.alu = alu; r.b = b;
    r.rdy = rdy; r.we = we; r.wa = wa; r.wd = wd; r.wb = wb;
    r.cnt = cnt; r.err = err; r.dchk = dchk;
    return r;
  endfunction

  initial begin
    logic [31:0] add6, sw, lw13, lw2, add0, beq, sh31, undef, add3, add4, lw7, lw0, mbad, add7;
    add6  = mk_ir(7'd0, 5'd6, 3'd0);
    sw    = mk_ir(7'd1, 5'd0, 3'd1);
    lw13  = mk_ir(7'd1, 5'd13, 3'd0);
    lw2   = mk_ir(7'd1, 5'd2, 3'd0);
    add0  = mk_ir(7'd0, 5'd0, 3'd0);
    beq   = mk_ir(7'd2, 5'd4, 3'd0);
    sh31  = mk_ir(7'd3, 5'd31, 3'd1);
    undef = mk_ir(7'h33, 5'd5, 3'd0);
    add3  = mk_ir(7'd0, 5'd3, 3'd0);
    add4  = mk_ir(7'd0, 5'd4, 3'd0);
    lw7   = mk_ir(7'd1, 5'd7, 3'd0);
    lw0   = mk_ir(7'd1, 5'd0, 3'd0);
    mbad  = mk_ir(7'd1, 5'd8, 3'd2);
    add7  = mk_ir(7'd0, 5'd7, 3'd0);

    //        rn vld ir     alu           b             rdy we wa     wd            wb            cnt    err dchk
    vt.push_back(v(1, 0, 32'd0, 32'd0,        32'd0,        1, 0, 5'd0,  32'd0,        32'd0,        32'd0, 0, 1)); // reset
    vt.push_back(v(0, 1, add6,  32'd50,       32'd0,        1, 1, 5'd6,  32'd50,       32'd50,       32'd1, 0, 0)); // ADD x6=50
    vt.push_back(v(0, 0, 32'd0, 32'd0,        32'd0,        1, 0, 5'd0,  32'd0,        32'd50,       32'd1, 0, 0)); // pulse ends
    vt.push_back(v(0, 1, sw,    32'd5,        32'hDEADBEEF, 1, 0, 5'd0,  32'd0,        32'd50,       32'd2, 0, 0)); // SW [5]
    vt.push_back(v(0, 1, lw13,  32'd5,        32'd0,        0, 0, 5'd0,  32'd0,        32'd50,       32'd2, 0, 0)); // LW x13
    vt.push_back(v(0, 1, add6,  32'd77,       32'd0,        1, 1, 5'd13, 32'hDEADBEEF, 32'hDEADBEEF, 32'd3, 0, 0)); // ignored ADD
    vt.push_back(v(0, 0, 32'd0, 32'd0,        32'd0,        1, 0, 5'd0,  32'd0,        32'hDEADBEEF, 32'd3, 0, 0));
    vt.push_back(v(0, 1, lw2,   32'd40,       32'd0,        0, 0, 5'd0,  32'd0,        32'hDEADBEEF, 32'd3, 1, 0)); // LW out of range
    vt.push_back(v(0, 0, 32'd0, 32'd0,        32'd0,        1, 1, 5'd2,  32'd0,        32'd0,        32'd4, 1, 0));
    vt.push_back(v(0, 1, add0,  32'd99,       32'd0,        1, 0, 5'd0,  32'd0,        32'd0,        32'd5, 1, 0)); // ADD x0
    vt.push_back(v(0, 1, beq,   32'd123,      32'd0,        1, 0, 5'd0,  32'd0,        32'd0,        32'd6, 1, 0)); // BEQ
    vt.push_back(v(0, 1, sh31,  32'h80000000, 32'd0,        1, 1, 5'd31, 32'h80000000, 32'h80000000, 32'd7, 1, 0)); // SH x31
    vt.push_back(v(0, 1, undef, 32'd1,        32'd0,        1, 0, 5'd0,  32'd0,        32'h80000000, 32'd8, 1, 0)); // undefined op
    vt.push_back(v(0, 1, sw,    32'd32,       32'd1,        1, 0, 5'd0,  32'd0,        32'h80000000, 32'd9, 1, 0)); // SW out of range
    vt.push_back(v(0, 1, add3,  32'd11,       32'd0,        1, 1, 5'd3,  32'd11,       32'd11,       32'd10, 1, 0)); // back-to-back
    vt.push_back(v(0, 1, add4,  32'd22,       32'd0,        1, 1, 5'd4,  32'd22,       32'd22,       32'd11, 1, 0));
    vt.push_back(v(0, 1, lw13,  32'd5,        32'd0,        0, 0, 5'd0,  32'd0,        32'd22,       32'd11, 1, 0)); // LW then reset
    vt.push_back(v(1, 0, 32'd0, 32'd0,        32'd0,        1, 0, 5'd0,  32'd0,        32'd0,        32'd0, 0, 1)); // RN in LOAD_WAIT
    vt.push_back(v(0, 0, 32'd0, 32'd0,        32'd0,        1, 0, 5'd0,  32'd0,        32'd0,        32'd0, 0, 0)); // no late write
    vt.push_back(v(0, 1, sw,    32'd0,        32'h1234,     1, 0, 5'd0,  32'd0,        32'd0,        32'd1, 0, 0)); // SW [0]
    vt.push_back(v(0, 1, sw,    32'h20,       32'd1,        1, 0, 5'd0,  32'd0,        32'd0,        32'd2, 1, 0)); // aliasing SW dropped
    vt.push_back(v(0, 1, lw7,   32'd0,        32'd0,        0, 0, 5'd0,  32'd0,        32'd0,        32'd2, 1, 0));
    vt.push_back(v(0, 0, 32'd0, 32'd0,        32'd0,        1, 1, 5'd7,  32'h1234,     32'h1234,     32'd3, 1, 0));
    vt.push_back(v(0, 1, lw0,   32'd0,        32'd0,        0, 0, 5'd0,  32'd0,        32'h1234,     32'd3, 1, 0)); // LW x0
    vt.push_back(v(0, 0, 32'd0, 32'd0,        32'd0,        1, 0, 5'd0,  32'd0,        32'h1234,     32'd4, 1, 0));
    vt.push_back(v(0, 1, mbad,  32'd3,        32'd9,        1, 0, 5'd0,  32'd0,        32'h1234,     32'd5, 1, 0)); // M_TYPE funct3=2
    vt.push_back(v(0, 1, add7,  32'd3,        32'd0,        1, 1, 5'd7,  32'd3,        32'd3,        32'd6, 1, 0)); // ADD x7=3
    vt.push_back(v(0, 0, 32'd0, 32'd0,        32'd0,        1, 0, 5'd0,  32'd0,        32'd3,        32'd6, 1, 0));

    RN = 1'b1; ex_valid = 1'b0; ex_ir = '0; ex_aluout = '0; ex_b = '0;
    @(posedge clk);
    #1;

    for (int i = 0; i < vt.size(); i++) begin
      RN        = vt[i].rn;
      ex_valid  = vt[i].vld;
      ex_ir     = vt[i].ir;
      ex_aluout = vt[i].alu;
      ex_b      = vt[i].b;
      @(posedge clk);
      #1;
      check($sformatf("v%0d_ready", i),  ex_ready,   vt[i].rdy);
      check($sformatf("v%0d_we", i),     rf_we,      vt[i].we);
      check($sformatf("v%0d_wb_out", i), WB_OUT,     vt[i].wb);
      check($sformatf("v%0d_retire", i), retire_cnt, vt[i].cnt);
      check($sformatf("v%0d_dm_err", i), dm_err,     vt[i].err);
      if (vt[i].we || vt[i].dchk) begin
        check($sformatf("v%0d_waddr", i), rf_waddr, vt[i].wa);
        check($sformatf("v%0d_wdata", i), rf_wdata, vt[i].wd);
      end
`ifdef IIITB_MEM_WB_FWD_EN
      check($sformatf("v%0d_fwd_valid", i), fwd_valid, vt[i].we);
      if (vt[i].we) begin
        check($sformatf("v%0d_fwd_rd", i),   fwd_rd,   vt[i].wa);
        check($sformatf("v%0d_fwd_data", i), fwd_data, vt[i].wd);
      end
`endif
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
